// File: rtl/led_ring_sequencer.sv
// LED ring mode controller: one-hot pattern on 8 LEDs driven by encoder steps (MANUAL)
// or an auto-scroll timer (AUTO), with a button cycling MANUAL -> AUTO -> PAUSE.
`timescale 1ns/1ps
module led_ring_sequencer #(
    parameter int unsigned PRESCALE = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_valid,
    input  logic       step_dir,
    input  logic       btn,
    input  logic       invert,
    output logic [7:0] led_out,
    output logic [1:0] mode,
    output logic [2:0] speed
);

    localparam int unsigned LED_W   = 8;
    localparam int unsigned SPEED_W = 3;
    localparam int unsigned PS_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
    localparam logic [LED_W-1:0]   Q_RESET   = 8'h01;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_PAUSE  = 2'b10
    } mode_t;

    mode_t              r_mode;
    logic [LED_W-1:0]   r_q;
    logic [SPEED_W-1:0] r_speed;
    logic               r_auto_dir;
    logic               r_btn_d;
    logic [PS_W-1:0]    r_pre;
    logic [SPEED_W-1:0] r_int;

    logic               w_btn_edge;
    logic               w_onehot;
    logic               w_run;
    logic               w_base_tick;
    logic [SPEED_W-1:0] w_limit;
    logic               w_interval_hit;
    logic               w_man_step;
    logic               w_speed_step;
    logic               w_rotate;
    logic               w_rot_dir;
    logic [LED_W-1:0]   w_rot_left;
    logic [LED_W-1:0]   w_rot_right;

    // A button edge pre-empts every step and timer action in the same cycle.
    assign w_btn_edge     = btn & ~r_btn_d;
    assign w_onehot       = (r_q != '0) && ((r_q & (r_q - 8'd1)) == '0);
    assign w_run          = (r_mode == MODE_AUTO) && !w_btn_edge;
    assign w_base_tick    = (r_pre == PS_W'(PRESCALE - 1));
    assign w_limit        = 3'(SPEED_MAX - r_speed);
    assign w_interval_hit = (r_int >= w_limit);
    assign w_man_step     = (r_mode == MODE_MANUAL) && step_valid && !w_btn_edge;
    assign w_speed_step   = w_run && step_valid;
    assign w_rotate       = w_man_step || (w_run && w_base_tick && w_interval_hit);
    assign w_rot_dir      = (r_mode == MODE_MANUAL) ? step_dir : r_auto_dir;
    assign w_rot_left     = {r_q[6:0], r_q[7]};
    assign w_rot_right    = {r_q[0], r_q[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_MANUAL;
            r_q        <= Q_RESET;
            r_speed    <= '0;
            r_auto_dir <= 1'b1;
            r_btn_d    <= 1'b0;
            r_pre      <= '0;
            r_int      <= '0;
        end else begin
            r_btn_d <= btn;

            if (w_btn_edge) begin
                case (r_mode)
                    MODE_MANUAL: r_mode <= MODE_AUTO;
                    MODE_AUTO:   r_mode <= MODE_PAUSE;
                    default:     r_mode <= MODE_MANUAL;
                endcase
            end

            // Corrupted pattern recovery outranks any rotation.
            if (!w_onehot) begin
                r_q <= Q_RESET;
            end else if (w_rotate) begin
                r_q <= w_rot_dir ? w_rot_left : w_rot_right;
            end

            if (w_man_step) begin
                r_auto_dir <= step_dir;
            end

            if (w_speed_step) begin
                if (step_dir && (r_speed != SPEED_MAX)) begin
                    r_speed <= r_speed + 3'd1;
                end else if (!step_dir && (r_speed != '0)) begin
                    r_speed <= r_speed - 3'd1;
                end
            end

            // Timer only runs while settled in AUTO; entering or leaving clears it.
            if (w_run) begin
                r_pre <= w_base_tick ? '0 : r_pre + PS_W'(1);
                if (w_base_tick) begin
                    r_int <= w_interval_hit ? '0 : r_int + 3'd1;
                end
            end else begin
                r_pre <= '0;
                r_int <= '0;
            end
        end
    end

    assign led_out = invert ? ~r_q : r_q;
    assign mode    = r_mode;
    assign speed   = r_speed;

    a_q_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(r_q));

endmodule

// File: tb/tb_led_ring_sequencer.sv
// Directed bench for led_ring_sequencer: vector table for single-cycle behaviour,
// hand-written sequences for auto timing, pause, collisions and async reset.
`timescale 1ns/1ps
module tb_led_ring_sequencer;

    logic       clk;
    logic       rst_n;
    logic       step_valid;
    logic       step_dir;
    logic       btn;
    logic       invert;
    logic [7:0] led_out;
    logic [1:0] mode;
    logic [2:0] speed;

    int checks;
    int failures;

    typedef struct {
        logic       sv;
        logic       sd;
        logic       b;
        logic       inv;
        logic [7:0] led;
        logic [1:0] md;
        logic [2:0] spd;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    led_ring_sequencer #(.PRESCALE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .btn        (btn),
        .invert     (invert),
        .led_out    (led_out),
        .mode       (mode),
        .speed      (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until led_out changes; n = ticks taken, or -1 if the budget expires.
    task automatic wait_change(input int budget, output int n);
        logic [7:0] prev;
        prev = led_out;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (led_out != prev) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic sd, input logic b, input logic inv,
                                input logic [7:0] led, input logic [1:0] md, input logic [2:0] spd);
        vec_t v;
        v.sv = sv; v.sd = sd; v.b = b; v.inv = inv;
        v.led = led; v.md = md; v.spd = spd;
        return v;
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step_valid = vecs[i].sv;
            step_dir   = vecs[i].sd;
            btn        = vecs[i].b;
            invert     = vecs[i].inv;
            tick();
            check($sformatf("vec%0d_led", i), int'(led_out), int'(vecs[i].led));
            check($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].md));
            check($sformatf("vec%0d_speed", i), int'(speed), int'(vecs[i].spd));
        end
        step_valid = 1'b0;
        btn        = 1'b0;
        invert     = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        checks = 0;
        failures = 0;

        //          sv    sd    btn   inv   led    mode  speed
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 2'd0, 3'd0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 2'd0, 3'd0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 2'd0, 3'd0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 2'd0, 3'd0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 2'd0, 3'd0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 2'd0, 3'd0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 2'd0, 3'd0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 2'd0, 3'd0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 2'd0, 3'd0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 2'd0, 3'd0);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 2'd0, 3'd0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 2'd0, 3'd0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'hFB, 2'd0, 3'd0);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hF7, 2'd0, 3'd0);
        vecs[14] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 2'd1, 3'd0);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h08, 2'd1, 3'd0);

        rst_n = 1'b0;
        step_valid = 1'b0;
        step_dir = 1'b0;
        btn = 1'b0;
        invert = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_led", int'(led_out), 8'h01);
        check("reset_mode", int'(mode), 0);
        check("reset_speed", int'(speed), 0);

        run_vecs(0, 11);

        // invert is combinational: no clock edge between these checks
        invert = 1'b1;
        #1;
        check("invert_same_cycle", int'(led_out), 8'hFB);
        invert = 1'b0;
        #1;
        check("invert_release", int'(led_out), 8'h04);

        // ends with step+button collision entering AUTO (edge E0), button held one more cycle
        run_vecs(12, 15);

        // speed 0: first rotation at E0+32, we are at E0+1
        wait_change(40, n);
        check("auto_first_period", n, 31);
        check("auto_first_led", int'(led_out), 8'h10);
        wait_change(40, n);
        check("auto_second_period", n, 32);
        check("auto_second_led", int'(led_out), 8'h20);

        // seven back-to-back steps raise speed to 7; interval already past new limit
        step_valid = 1'b1;
        step_dir = 1'b1;
        repeat (7) tick();
        step_valid = 1'b0;
        check("speed_up_to_7", int'(speed), 7);
        check("speed_steps_no_rotate", int'(led_out), 8'h20);
        wait_change(10, n);
        check("speed_change_next_tick", n, 1);
        check("speed_change_led", int'(led_out), 8'h40);
        wait_change(10, n);
        check("fast_period", n, 4);
        check("fast_led", int'(led_out), 8'h80);
        step_valid = 1'b1;
        repeat (2) tick();
        step_valid = 1'b0;
        check("speed_saturate", int'(speed), 7);
        wait_change(10, n);
        check("fast_period_after_sat", n, 2);
        check("fast_wrap_led", int'(led_out), 8'h01);

        // PAUSE freezes q and speed and ignores steps
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("pause_mode", int'(mode), 2);
        check("pause_led", int'(led_out), 8'h01);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step_valid = 1'b1;
            step_dir = i[0];
            tick();
            if (led_out != 8'h01 || speed != 3'd7 || mode != 2'd2) bad++;
        end
        step_valid = 1'b0;
        check("pause_frozen_cycles", bad, 0);
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("pause_to_manual_mode", int'(mode), 0);
        check("pause_to_manual_led", int'(led_out), 8'h01);
        check("speed_persists", int'(speed), 7);
        step_valid = 1'b1;
        step_dir = 1'b1;
        tick();
        step_valid = 1'b0;
        check("manual_after_pause", int'(led_out), 8'h02);

        // button edge on the same edge as an auto rotation drops the rotation
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("enter_auto_a", int'(mode), 1);
        repeat (3) tick();
        check("auto_a_pre_rotate", int'(led_out), 8'h02);
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("rotate_collision_mode", int'(mode), 2);
        check("rotate_collision_led", int'(led_out), 8'h02);
        tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("back_to_manual", int'(mode), 0);
        tick();

        // AUTO at speed 5, then async reset mid-period
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("enter_auto_b", int'(mode), 1);
        step_valid = 1'b1;
        step_dir = 1'b0;
        repeat (2) tick();
        step_valid = 1'b0;
        check("speed_down_to_5", int'(speed), 5);
        repeat (3) tick();
        check("auto_b_mid_led", int'(led_out), 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_led", int'(led_out), 8'h01);
        check("async_reset_mode", int'(mode), 0);
        check("async_reset_speed", int'(speed), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // after reset: speed 0 and auto_dir left, so one full 32-cycle period then 01->02
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("post_reset_auto", int'(mode), 1);
        wait_change(40, n);
        check("post_reset_period", n, 32);
        check("post_reset_led", int'(led_out), 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_ring_sequencer.md
# led_ring_sequencer

Mode controller for the 8-LED ring on the board. It owns the one-hot LED pattern and shares it between two sources: rotary step events from the encoder decoder and an internal auto-scroll timer. A debounced push-button cycles the mode. The block sits between the encoder decoder (which supplies one-cycle step pulses) and the board LED pins.

## Interface
- `PRESCALE`, default 500000: clk cycles per base tick. Legal range is ≥2.
- `SPEED_MAX`, fixed at 7: top of the speed range. The speed field is 3 bits.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `step_valid`  in  1  one-cycle pulse, one encoder detent.
- `step_dir`  in  1  1 = rotate toward MSB (left), 0 = toward LSB (right). Meaningful only with `step_valid`.
- `btn`  in  1  debounced button level.
- `invert`  in  1  1 = drive the complement of the pattern.
- `led_out`  out  8  LED drive: `invert ? ~q : q`. Combinational from registered `q`.
- `mode`  out  2  registered state: 00 MANUAL, 01 AUTO, 10 PAUSE.
- `speed`  out  3  registered auto speed, 0..7.

## Operation
**Reset values**
- `q` = 8'b0000_0001, `mode` = MANUAL, `speed` = 0.
- `auto_dir` = 1, `btn_d` = 0, prescaler = 0, interval counter = 0.

**Button edge**
- `btn_d` registers `btn` every cycle.
- Rising edge: `btn & ~btn_d`.
- Mode advances on an edge: MANUAL→AUTO→PAUSE→MANUAL.
- Encoding 11 is unreachable. If it is ever reached, the next edge forces MANUAL.

**MANUAL**
- On `step_valid`, rotate `q`:
  - dir=1: `{q[6:0],q[7]}`
  - dir=0: `{q[0],q[7:1]}`
- Latch `auto_dir` <= `step_dir`.
- Timer counters are held at 0.

**AUTO**
- Prescaler counts 0..PRESCALE-1 and emits a base tick on wrap.
- Interval counter counts base ticks. When it reaches `7-speed`, it clears and `q` rotates once in `auto_dir`.
- Rotation period is therefore `(8-speed)*PRESCALE` cycles.
- On `step_valid`, adjust `speed`; `q` is not rotated by steps:
  - dir=1: increment, saturating at 7.
  - dir=0: decrement, saturating at 0.
- A speed change takes effect at the next interval-counter comparison. If the counter already exceeds the new `7-speed`, rotate and clear on the next base tick.

**PAUSE**
- `q` and `speed` are frozen.
- `step_valid` is ignored.
- Counters are held at 0.

**Priorities and simultaneous events**
- Button edge beats `step_valid` in the same cycle: the mode changes and the step is dropped. No rotate, no speed change.
- Button edge beats a timer rotation in the same cycle: the rotation is dropped.
- Entering AUTO always clears both counters, so the first auto rotation comes a full period later.
- `speed` persists across modes. It returns to 0 only on reset.

**Pattern integrity**
- If `q` is ever not one-hot, `q` is reloaded to 8'b0000_0001 on the next edge, in any mode. This takes priority over rotation.
- Assertion: `q` is one-hot on every cycle after reset release.

**Reset mid-operation**
- Asserting `rst_n` low forces all reset values immediately, without waiting for a clock edge.
- Release is synchronised by the board-level reset synchroniser, not by this block.

## Timing
- Step to LED: `led_out` changes on the clk edge that samples `step_valid`=1. Visible one cycle after the pulse is presented.
- Button: `mode` updates on the edge where `btn`=1 and `btn_d`=0 are sampled.
- `invert` toggle: reflected on `led_out` in the same cycle (combinational).
- Auto rotations: first rotation occurs exactly `(8-speed)*PRESCALE` cycles after the edge that entered AUTO. Subsequent rotations are periodic with the same interval.
- Back-to-back `step_valid` pulses on consecutive cycles each rotate (MANUAL) or each adjust speed (AUTO). No pulse is lost except when it collides with a button edge.

## Test plan
All scenarios use `PRESCALE`=4.
1. **Reset, then steps.** Release reset; apply 3 steps with dir=1 → `led_out` 01, 02, 04, 08. Then 4 steps with dir=0 from 08 → 04, 02, 01, 80.
2. **Auto timing.** Set speed=0 with dir=1 in MANUAL. Press `btn` → `mode`=01. `q` rotates left every 32 cycles; the first rotation comes 32 cycles after the mode edge. Then 7 steps with dir=1 → `speed`=7, period 4 cycles. Then 2 more steps → `speed` stays 7.
3. **Collision.** Assert `step_valid` in the same cycle as a `btn` rising edge, in MANUAL → `mode`=AUTO, `q` unchanged, `speed` unchanged.
4. **Pause and return.** In AUTO press `btn` → PAUSE. `q` stays frozen for 100 cycles and steps are ignored. Press again → MANUAL with the `q` value preserved.
5. **Invert.** `q`=8'h04, `invert`=1 → `led_out`=8'hFB in the same cycle.
6. **Async reset.** In AUTO at speed 5, pull `rst_n` low mid-period → `led_out`=01, `mode`=00, `speed`=0 before the next clk edge. Prescaler restarts from 0.
